video_pixel_feeder: RTL and testbench

VIDEO_PIXEL_FEEDER -- requirements
Module: video_pixel_feeder

---
 rtl/video_pixel_feeder.sv | 136 +++++++++++++
 tb/tb_video_pixel_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/video_pixel_feeder.sv
// video_pixel_feeder
//   Pulls pixels from a first-word-fall-through FIFO in step with an external
//   display timing generator and presents them, with the sync/blank signals,
//   one cycle later on aligned registered outputs.
//
// Ports
//   pixel_clk, pixel_rst_n      clock, asynchronous active-low reset
//   hs_i, vs_i                  syncs from timing generator (active low)
//   blank_i                     1 = active display pixel
//   fifo_rdata, fifo_empty      FIFO head word / empty flag
//   fifo_rd                     combinational pop of FIFO head
//   hs_o, vs_o, blank_o, rgb_o  registered, mutually aligned video outputs
//   frame_start                 pulse alongside pixel (0,0) of each frame
//   underflow_cnt               saturating count of pixels emitted while empty
//   frame_err                   sticky: a frame had the wrong pixel count
module video_pixel_feeder #(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        blank_i,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        hs_o,
    output logic        vs_o,
    output logic        blank_o,
    output logic [23:0] rgb_o,
    output logic        frame_start,
    output logic [15:0] underflow_cnt,
    output logic        frame_err
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

    typedef enum logic [1:0] {WAIT_VS, WAIT_ACT, RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_vs_d;
    logic [XW-1:0] r_x, w_x_nxt, w_bx;
    logic [YW-1:0] r_y, w_y_nxt, w_by;
    logic          r_full, w_full_nxt, w_bfull;   // all HDISP*VDISP pixels seen
    logic          r_ovf, w_ovf_nxt, w_bovf;      // at least one pixel beyond that
    logic          w_vs_fall, w_cnt_ok, w_err, w_armed, w_entry, w_pix;

    assign w_vs_fall = r_vs_d & ~vs_i;
    assign w_cnt_ok  = r_full & ~r_ovf;
    assign w_err     = (r_state == RUN) & w_vs_fall & ~w_cnt_ok;

    // "Armed" = ready to take pixel (0,0) this cycle. A vs fall is resolved
    // first, so an active pixel on the same cycle opens the new frame.
    assign w_armed = (r_state == WAIT_ACT) |
                     (w_vs_fall & ((r_state == WAIT_VS) | ((r_state == RUN) & w_cnt_ok)));
    assign w_entry = w_armed & blank_i;
    assign w_pix   = w_entry | ((r_state == RUN) & ~w_vs_fall & blank_i);
    assign fifo_rd = pixel_rst_n & w_pix & ~fifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        if (w_err)
            w_state_nxt = WAIT_VS;
        else if (w_entry)
            w_state_nxt = RUN;
        else if (w_armed)
            w_state_nxt = WAIT_ACT;
    end

    // Position tracking: the entry pixel advances from (0,0) regardless of
    // leftovers from the previous frame. Once full, x/y hold and ovf latches.
    always_comb begin
        w_bx       = w_entry ? '0 : r_x;
        w_by       = w_entry ? '0 : r_y;
        w_bfull    = w_entry ? 1'b0 : r_full;
        w_bovf     = w_entry ? 1'b0 : r_ovf;
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_full_nxt = r_full;
        w_ovf_nxt  = r_ovf;
        if (w_pix) begin
            w_x_nxt    = w_bx;
            w_y_nxt    = w_by;
            w_full_nxt = w_bfull;
            w_ovf_nxt  = w_bovf;
            if (w_bfull)
                w_ovf_nxt = 1'b1;
            else if (w_bx != X_LAST)
                w_x_nxt = w_bx + 1'b1;
            else if (w_by != Y_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = w_by + 1'b1;
            end else
                w_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            r_state       <= WAIT_VS;
            r_vs_d        <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_full        <= 1'b0;
            r_ovf         <= 1'b0;
            rgb_o         <= 24'h000000;
            hs_o          <= 1'b1;
            vs_o          <= 1'b1;
            blank_o       <= 1'b0;
            frame_start   <= 1'b0;
            underflow_cnt <= 16'h0000;
            frame_err     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vs_d      <= vs_i;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_full      <= w_full_nxt;
            r_ovf       <= w_ovf_nxt;
            rgb_o       <= fifo_rd ? fifo_rdata : 24'h000000;
            hs_o        <= hs_i;
            vs_o        <= vs_i;
            blank_o     <= blank_i;
            frame_start <= w_entry;
            if (w_pix && fifo_empty && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
            if (w_err)
                frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Bench for video_pixel_feeder (8x4 frame). A behavioural model predicts each
// cycle's pop and the outputs due one cycle later; those predictions queue in
// a scoreboard and are compared when the registered outputs appear.
module tb_video_pixel_feeder;

    localparam int H = 8, V = 4, TOT = H * V;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hs_i, vs_i, blank_i;
    logic [23:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd, hs_o, vs_o, blank_o, frame_start, frame_err;
    logic [23:0] rgb_o;
    logic [15:0] underflow_cnt;

    always #5 clk = ~clk;

    video_pixel_feeder #(.HDISP(H), .VDISP(V)) dut (
        .pixel_clk(clk), .pixel_rst_n(rst_n),
        .hs_i(hs_i), .vs_i(vs_i), .blank_i(blank_i),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .hs_o(hs_o), .vs_o(vs_o), .blank_o(blank_o), .rgb_o(rgb_o),
        .frame_start(frame_start), .underflow_cnt(underflow_cnt), .frame_err(frame_err)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        fs, hs, vs, bl, err;
        logic [15:0] uf;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] fq[$];
    int          n_chk = 0, n_pass = 0;

    // model state: m 0=waiting vs, 1=waiting active, 2=running
    int   m = 0, mcnt = 0, muf = 0;
    logic mpvs = 1'b1, merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic fill(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + 24'(i));
    endtask

    // One pixel clock: drive, predict, check the pop, then check outputs.
    task automatic step(input logic h, input logic v, input logic b, input logic fe);
        exp_t e;
        logic pop, pix, fall;
        hs_i = h; vs_i = v; blank_i = b;
        fifo_empty = fe || (fq.size() == 0);
        fifo_rdata = (fq.size() > 0) ? fq[0] : 24'h0;
        #1;
        pop = 1'b0; pix = 1'b0;
        e.fs = 1'b0;
        if (!rst_n) begin
            m = 0; mpvs = 1'b1; mcnt = 0; muf = 0; merr = 1'b0;
            e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
        end else begin
            fall = !v && mpvs;
            if (fall) begin
                if (m == 2 && mcnt != TOT) begin merr = 1'b1; m = 0; end
                else m = 1;
            end
            if (m == 1 && b) begin m = 2; mcnt = 0; e.fs = 1'b1; pix = 1'b1; end
            else if (m == 2 && b) pix = 1'b1;
            if (pix) begin
                mcnt++;
                if (fifo_empty) muf = (muf == 65535) ? 65535 : muf + 1;
                else pop = 1'b1;
            end
            mpvs = v;
            e.rgb = pop ? fifo_rdata : 24'h0;
            e.hs = h; e.vs = v; e.bl = b;
        end
        e.uf = 16'(muf); e.err = merr;
        chk("fifo_rd", fifo_rd, pop);
        sb.push_back(e);
        @(posedge clk); #1;
        if (pop) void'(fq.pop_front());
        e = sb.pop_front();
        chk("rgb_o", rgb_o, e.rgb);
        chk("frame_start", frame_start, e.fs);
        chk("hs_o", hs_o, e.hs);
        chk("vs_o", vs_o, e.vs);
        chk("blank_o", blank_o, e.bl);
        chk("underflow_cnt", underflow_cnt, e.uf);
        chk("frame_err", frame_err, e.err);
        @(negedge clk);
    endtask

    // 7 lines x 12 clocks: vsync line, back porch, 4 active lines, front porch.
    // nact limits active pixels; [st_at, st_at+st_n) forces FIFO empty;
    // rst_at pulses reset on that active pixel (-1 = none).
    task automatic frame(input int nact, input int st_at, input int st_n, input int rst_at);
        int p;
        logic act, b, fe;
        p = 0;
        for (int L = 0; L < 7; L++) begin
            for (int c = 0; c < 12; c++) begin
                act = (L >= 2 && L <= 5 && c < 8);
                b   = act && (p < nact);
                fe  = b && (p >= st_at) && (p < st_at + st_n);
                rst_n = !(act && p == rst_at);
                step(!(c >= 8 && c < 10), L != 0, b, fe);
                if (act) p++;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; hs_i = 1'b1; vs_i = 1'b1; blank_i = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = 24'h0;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);

        // full frame, all words delivered in order
        fill(24'h010000, TOT);
        frame(TOT, 0, 0, -1);
        chk("full_pops", fq.size(), 0);
        chk("full_uf", underflow_cnt, 0);

        // 5 starved pixels mid-line
        fill(24'h020000, TOT);
        frame(TOT, 10, 5, -1);
        chk("starve_left", fq.size(), 5);
        chk("starve_uf", underflow_cnt, 5);
        fq.delete();

        // short frame -> error, next frame skipped, then resume
        fill(24'h030000, 64);
        frame(TOT - 1, 0, 0, -1);
        chk("short_pops", fq.size(), 33);
        frame(TOT, 0, 0, -1);
        chk("short_err", frame_err, 1);
        chk("skip_nopop", fq.size(), 33);
        frame(TOT, 0, 0, -1);
        chk("resume_pops", fq.size(), 1);
        chk("err_sticky", frame_err, 1);

        // reset mid-frame: pops stop until the next vsync
        fq.delete();
        fill(24'h0A0000, TOT);
        frame(TOT, 0, 0, 12);
        chk("rst_pops", fq.size(), 20);
        chk("rst_err", frame_err, 0);
        fill(24'h0B0000, 12);
        frame(TOT, 0, 0, -1);
        chk("rst_resume", fq.size(), 0);
        chk("rst_uf", underflow_cnt, 0);

        // underflow saturation
        fq.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("uf_sat", underflow_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
